// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, stored-frame size and the
// 12-bit pixel type used between the frame buffer and the colour pins.
package vga_pkg;

    // Default monitor timing (640x480 @ 60 Hz, 25 MHz pixel rate).
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam bit SYNC_POL_DEF = 1'b0;

    // Stored frame is a quarter of the display in each direction.
    localparam int FRAME_W_DEF  = 160;
    localparam int FRAME_H_DEF  = 120;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    function automatic logic [11:0] pack_pixel(input pixel_t p);
        return {p.r, p.g, p.b};
    endfunction

    function automatic pixel_t unpack_pixel(input logic [11:0] w);
        pixel_t p;
        p.r = w[11:8];
        p.g = w[7:4];
        p.b = w[3:0];
        return p;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for one display frame, with active-area and sync decode of
// the current count and a one-clk pulse on the wrap back to (0,0).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce_i,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          active_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          frame_start_o
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          frame_start_q, frame_start_d;

    // Advance the raster position on each pixel enable; flag the frame wrap.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        if (pix_ce_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Counter registers; frame_start is rewritten every clk so it stays one clk wide.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_o          = ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vs_o          = ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/frame_scanout.sv
// Reads the stored frame in raster order and drives VGA pins. Each stored
// pixel is replicated HS times across and VS times down; counters to pins
// take exactly two pixel-enable periods, syncs delayed alongside the data.
module frame_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int FRAME_W  = FRAME_W_DEF,
    parameter int FRAME_H  = FRAME_H_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF,
    localparam int RW      = $clog2(FRAME_H),
    localparam int CW      = $clog2(FRAME_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    output logic          rd_en,
    output logic [RW-1:0] rd_row,
    output logic [CW-1:0] rd_col,
    input  logic [11:0]   rd_data,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          frame_start
);

    localparam int HW  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int HS  = H_ACTIVE / FRAME_W;
    localparam int VS  = V_ACTIVE / FRAME_H;
    localparam int HSW = (HS > 1) ? $clog2(HS) : 1;
    localparam int VSW = (VS > 1) ? $clog2(VS) : 1;
    localparam logic [HSW-1:0] HSUB_LAST = HSW'(HS - 1);
    localparam logic [VSW-1:0] VSUB_LAST = VSW'(VS - 1);

    // Replication only works for whole-number scale factors.
    if (((H_ACTIVE % FRAME_W) != 0) || ((V_ACTIVE % FRAME_H) != 0)) begin : g_bad_scale
        $error("frame_scanout: active area is not an integer multiple of the stored frame");
    end

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active, hs, vs;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_ce_i      (pix_ce),
        .h_o           (h),
        .v_o           (v),
        .active_o      (active),
        .hs_o          (hs),
        .vs_o          (vs),
        .frame_start_o (frame_start)
    );

    // S1: read request plus the timing bits that travel with it.
    logic           rd_en_q, rd_en_d;
    logic [RW-1:0]  rd_row_q, rd_row_d;
    logic [CW-1:0]  rd_col_q, rd_col_d;
    logic [HSW-1:0] hsub_q, hsub_d;
    logic [VSW-1:0] vsub_q, vsub_d;
    logic           act1_q, act1_d;
    logic           hs1_q, hs1_d;
    logic           vs1_q, vs1_d;

    // S2: pin drivers.
    pixel_t         rgb_q, rgb_d;
    logic           vga_hs_q, vga_hs_d;
    logic           vga_vs_q, vga_vs_d;

    // Next state for the replicating address generator (S1) and the pin stage (S2).
    always_comb begin
        rd_en_d  = rd_en_q;
        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q;
        hsub_d   = hsub_q;
        vsub_d   = vsub_q;
        act1_d   = act1_q;
        hs1_d    = hs1_q;
        vs1_d    = vs1_q;
        rgb_d    = rgb_q;
        vga_hs_d = vga_hs_q;
        vga_vs_d = vga_vs_q;
        if (pix_ce) begin
            rd_en_d = active;
            act1_d  = active;
            hs1_d   = hs;
            vs1_d   = vs;
            // Addresses only move on visible pixels and hold through blanking.
            if (active) begin
                if (h == '0) begin
                    rd_col_d = '0;
                    hsub_d   = '0;
                    if (v == '0) begin
                        rd_row_d = '0;
                        vsub_d   = '0;
                    end else if (vsub_q == VSUB_LAST) begin
                        rd_row_d = rd_row_q + 1'b1;
                        vsub_d   = '0;
                    end else begin
                        vsub_d = vsub_q + 1'b1;
                    end
                end else if (hsub_q == HSUB_LAST) begin
                    rd_col_d = rd_col_q + 1'b1;
                    hsub_d   = '0;
                end else begin
                    hsub_d = hsub_q + 1'b1;
                end
            end
            // rd_data answers the address S1 presented one clk earlier.
            rgb_d    = act1_q ? unpack_pixel(rd_data) : '0;
            vga_hs_d = hs1_q;
            vga_vs_d = vs1_q;
        end
    end

    // Pipeline registers; syncs idle at their inactive level out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q  <= 1'b0;
            rd_row_q <= '0;
            rd_col_q <= '0;
            hsub_q   <= '0;
            vsub_q   <= '0;
            act1_q   <= 1'b0;
            hs1_q    <= ~SYNC_POL;
            vs1_q    <= ~SYNC_POL;
            rgb_q    <= '0;
            vga_hs_q <= ~SYNC_POL;
            vga_vs_q <= ~SYNC_POL;
        end else begin
            rd_en_q  <= rd_en_d;
            rd_row_q <= rd_row_d;
            rd_col_q <= rd_col_d;
            hsub_q   <= hsub_d;
            vsub_q   <= vsub_d;
            act1_q   <= act1_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            rgb_q    <= rgb_d;
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
        end
    end

    assign rd_en  = rd_en_q;
    assign rd_row = rd_row_q;
    assign rd_col = rd_col_q;
    assign vga_r  = rgb_q.r;
    assign vga_g  = rgb_q.g;
    assign vga_b  = rgb_q.b;
    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;

endmodule
